rv_fetch_ctrl: RTL and testbench

Fetch controller that sequences the word-addressed, combinational instruction memory. Holds the program counter, drives the memory address, captures returned instructions into a small FIFO, and presents them to the decode stage over a valid/ready handshake. Handles branch/jump redirects with a FIFO flush, and halts with a fault on misaligned or out-of-range fetch addresses.

---
 rtl/rv_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rv_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_ctrl.sv
// rtl/rv_fetch_ctrl.sv - instruction fetch controller with fetch buffer, redirect flush and fault halt
//
// Purpose: holds the byte PC, addresses a word-indexed combinational
// instruction memory, buffers fetched words in a small FIFO and hands them
// to decode over a valid/ready handshake.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   fetch_en_i     run request from the core
//   redirect_i     one-cycle taken branch/jump strobe
//   redirect_pc_i  redirect target byte address
//   imem_addr_o    word index into instruction memory
//   imem_rdata_i   combinational instruction memory read data
//   instr_valid_o  FIFO head valid
//   instr_o        FIFO head instruction (0 when empty)
//   instr_pc_o     FIFO head byte PC (0 when empty)
//   instr_ready_i  decode accepts the head entry
//   fault_o        sticky fetch fault
//   fault_pc_o     offending byte PC
module rv_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 1024,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_en_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   output logic        fault_o,
   output logic [31:0] fault_pc_o
);

   localparam int             PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [31:0]    IMEM_BYTES = 32'(IMEM_WORDS * 4);
   localparam logic [PTR_W:0] DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [31:0]    pc;
   logic [31:0]    fifo_instr [FIFO_DEPTH];
   logic [31:0]    fifo_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;

   logic full, pop, push, redir_act, redir_bad, overrun;

   assign full          = (count == DEPTH_C);
   assign instr_valid_o = (count != '0);
   assign pop           = instr_valid_o & instr_ready_i;
   assign redir_bad     = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i >= IMEM_BYTES);
   assign imem_addr_o   = {2'b00, pc[31:2]};
   assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : 32'h0;
   assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr]    : 32'h0;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic: a redirect overrides every other transition
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (redirect_i) begin
               if (redir_bad) state_nxt = HALT;
            end else if (fetch_en_i) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (redirect_i) begin
               if (redir_bad) state_nxt = HALT;
            end else if (overrun) begin
               state_nxt = HALT;
            end else if (!fetch_en_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = state;
      endcase
   end

   // Per-state control strobes; HALT ignores redirects and never pushes
   always_comb begin
      redir_act = 1'b0;
      overrun   = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: redir_act = redirect_i;
         FETCH: begin
            redir_act = redirect_i;
            // pc reaching the end means the last word was already pushed
            overrun   = !redirect_i && (pc >= IMEM_BYTES);
            push      = !redirect_i && !overrun && (!full || pop);
         end
         default: ;
      endcase
   end

   // PC, FIFO bookkeeping and fault capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc         <= RESET_PC;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         fault_o    <= 1'b0;
         fault_pc_o <= 32'h0;
      end else if (redir_act) begin
         // Flush discards everything, including whatever a same-cycle pop left
         pc     <= redirect_pc_i;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         if (redir_bad) begin
            fault_o    <= 1'b1;
            fault_pc_o <= redirect_pc_i;
         end
      end else begin
         if (overrun) begin
            fault_o    <= 1'b1;
            fault_pc_o <= pc;
         end
         if (push) begin
            pc     <= pc + 32'd4;
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Buffer storage needs no reset; outputs are gated by count
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata_i;
         fifo_pc[wr_ptr]    <= pc;
      end
   end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb/tb_rv_fetch_ctrl.sv - self-checking bench for rv_fetch_ctrl against a queue-based reference model
module tb_rv_fetch_ctrl;

   localparam int          DEPTH      = 2;
   localparam logic [31:0] IMEM_BYTES = 32'h0000_1000;

   logic        clk;
   logic        reset_n;
   logic        fetch_en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        fault;
   logic [31:0] fault_pc;

   rv_fetch_ctrl #(
      .RESET_PC   (32'h0),
      .IMEM_WORDS (1024),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fetch_en_i    (fetch_en),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_addr_o   (imem_addr),
      .imem_rdata_i  (imem_rdata),
      .instr_valid_o (instr_valid),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc),
      .instr_ready_i (instr_ready),
      .fault_o       (fault),
      .fault_pc_o    (fault_pc)
   );

   // Memory image: imem[k] = 0x1000_0000 + k
   assign imem_rdata = 32'h1000_0000 + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: decoded queue of {pc, instr} plus run/halt flags
   logic [63:0] q[$];
   logic [31:0] m_pc;
   bit          m_run;
   bit          m_halt;
   logic        m_fault;
   logic [31:0] m_fault_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc       = 32'h0;
      m_run      = 0;
      m_halt     = 0;
      m_fault    = 1'b0;
      m_fault_pc = 32'h0;
   endtask

   task automatic model_step(input bit fe, input bit rd, input logic [31:0] rpc, input bit rdy);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (m_halt) return;
      if (rd) begin
         q.delete();
         m_pc = rpc;
         if (rpc % 4 != 0 || rpc >= IMEM_BYTES) begin
            m_halt     = 1;
            m_fault    = 1'b1;
            m_fault_pc = rpc;
         end
         return;
      end
      if (!m_run) begin
         if (fe) m_run = 1;
         return;
      end
      if (m_pc >= IMEM_BYTES) begin
         m_halt     = 1;
         m_fault    = 1'b1;
         m_fault_pc = m_pc;
         return;
      end
      if (q.size() < DEPTH) begin
         q.push_back({m_pc, 32'h1000_0000 + m_pc / 4});
         m_pc = m_pc + 4;
      end
      if (!fe) m_run = 0;
   endtask

   task automatic check_outputs();
      chk("valid",      {31'b0, instr_valid}, {31'b0, q.size() != 0});
      chk("instr",      instr,     (q.size() != 0) ? q[0][31:0]  : 32'h0);
      chk("instr_pc",   instr_pc,  (q.size() != 0) ? q[0][63:32] : 32'h0);
      chk("imem_addr",  imem_addr, m_pc / 4);
      chk("fault",      {31'b0, fault}, {31'b0, m_fault});
      chk("fault_pc",   fault_pc,  m_fault_pc);
   endtask

   // One clock cycle: drive at the negedge, check, advance the model
   task automatic cyc(input bit fe, input bit rd, input logic [31:0] rpc, input bit rdy);
      fetch_en    = fe;
      redirect    = rd;
      redirect_pc = rpc;
      instr_ready = rdy;
      #1;
      check_outputs();
      model_step(fe, rd, rpc, rdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      fetch_en = 0; redirect = 0; redirect_pc = 0; instr_ready = 0;
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; fetch_en = 0; redirect = 0; redirect_pc = 0; instr_ready = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      // Reset state
      chk("rst_valid",    {31'b0, instr_valid}, 32'h0);
      chk("rst_instr",    instr,     32'h0);
      chk("rst_instr_pc", instr_pc,  32'h0);
      chk("rst_addr",     imem_addr, 32'h0);
      chk("rst_fault",    {31'b0, fault}, 32'h0);
      chk("rst_fault_pc", fault_pc,  32'h0);
      reset_n = 1'b1;

      // Start-up stream with ready held high
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("start_valid_c2", {31'b0, instr_valid}, 32'h1);
      chk("start_instr_c2", instr, 32'h1000_0000);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
      chk("stream_pc", instr_pc, 32'd24);

      // Backpressure from reset
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      chk("bp_addr",  imem_addr, 32'd2);
      chk("bp_head",  instr_pc,  32'd0);
      chk("bp_valid", {31'b0, instr_valid}, 32'h1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);

      // Redirect while full with a same-cycle pop
      cyc(1, 1, 32'h100, 1);
      chk("redir_flush_valid", {31'b0, instr_valid}, 32'h0);
      chk("redir_addr", imem_addr, 32'h40);
      cyc(1, 0, 0, 1);
      chk("redir_head_pc", instr_pc, 32'h100);
      chk("redir_head_instr", instr, 32'h1000_0040);

      // Randomized traffic with in-range aligned redirects
      for (int i = 0; i < 250; i++) begin
         bit          rd;
         logic [31:0] tgt;
         rd  = ($urandom_range(0, 15) == 0);
         tgt = 32'($urandom_range(0, 512)) * 4;
         cyc(1, rd, tgt, 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset mid-stream
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid",    {31'b0, instr_valid}, 32'h0);
      chk("arst_instr",    instr,     32'h0);
      chk("arst_instr_pc", instr_pc,  32'h0);
      chk("arst_addr",     imem_addr, 32'h0);
      chk("arst_fault",    {31'b0, fault}, 32'h0);
      model_reset();
      fetch_en = 0; redirect = 0; instr_ready = 0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("arst_idle", {31'b0, instr_valid}, 32'h0);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("refetch_pc", instr_pc, 32'h0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);

      // Sequential overrun at the end of memory
      cyc(1, 1, 32'hFF8, 1);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
      chk("ovr_fault",    {31'b0, fault}, 32'h1);
      chk("ovr_fault_pc", fault_pc, 32'h1000);
      cyc(1, 1, 32'h0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
      chk("ovr_halt_valid", {31'b0, instr_valid}, 32'h0);

      // Misaligned redirect faults and halts
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 32'h102, 0);
      chk("mis_fault",    {31'b0, fault}, 32'h1);
      chk("mis_fault_pc", fault_pc, 32'h102);
      cyc(1, 1, 32'h0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
      chk("mis_no_valid", {31'b0, instr_valid}, 32'h0);
      chk("mis_pc_held",  imem_addr, 32'h102 >> 2);

      // Out-of-range redirect from IDLE
      do_reset();
      cyc(0, 1, 32'h1000, 1);
      cyc(0, 0, 0, 1);
      chk("oor_fault_pc", fault_pc, 32'h1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
